// File: rtl/hazard_forwarding_unit_if.sv
// ID-stage <-> hazard/forwarding unit bundle: ID instruction fields in, stall and forward selects out.
// Latency: n/a (wires only); all unit outputs are combinational from the ID fields and the unit's shadow slots.
// Backpressure: the stall lines (control_mux, pc_load_enable, ifid_load_enable) are the only hold mechanism.
// Ports: master = ID stage (drives id_* fields), slave = hazard_forwarding_unit (drives selects/stall lines).
// Optional HAZARD_STALL_COUNT_EN adds the 32-bit stall_count debug counter.
interface hazard_forwarding_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_rf_enable;
  logic                  id_load_instr;
  logic                  control_mux;
  logic                  pc_load_enable;
  logic                  ifid_load_enable;
  logic [1:0]            fwd_sel_a;
  logic [1:0]            fwd_sel_b;
  logic                  hazard_state;
`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0]           stall_count;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_rf_enable, id_load_instr,
    input  control_mux, pc_load_enable, ifid_load_enable, fwd_sel_a, fwd_sel_b, hazard_state
`ifdef HAZARD_STALL_COUNT_EN
    , input stall_count
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_rf_enable, id_load_instr,
    output control_mux, pc_load_enable, ifid_load_enable, fwd_sel_a, fwd_sel_b, hazard_state
`ifdef HAZARD_STALL_COUNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// Load-use hazard detection and EX/MEM/WB forwarding select generation for a 5-stage MIPS pipeline.
// Latency: selects/stall are combinational in ID; shadow EX/MEM/WB slots advance every clk edge.
// Backpressure: a load-use hazard holds PC and IF/ID and injects LOAD_USE_STALLS bubbles into ID/EX.
// Ports: clk, reset (async, active-high), hz (slave modport of hazard_forwarding_unit_if).
// Optional HAZARD_STALL_COUNT_EN: saturating 32-bit count of cycles with control_mux = 1.
module hazard_forwarding_unit #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_STALLS = 1   // legal range 1..3
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_forwarding_unit_if.slave  hz
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic                  rf_en;
    logic                  load;
  } slot_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  slot_t  ex_q, mem_q, wb_q;
  slot_t  ex_d;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic   hazard;
  logic   stall;

  // $0 is hardwired zero, so a write to it never produces a dependency.
  function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_W-1:0] r);
    return s.rf_en && (s.dest == r) && (r != '0);
  endfunction

  // Youngest producer wins. A load still in EX has no data yet, so it cannot
  // forward; that case is covered by the stall and the select is don't-care.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] r, input logic used,
                                         input slot_t ex, input slot_t mem, input slot_t wb);
    if (!used)                              return 2'b00;
    else if (slot_match(ex, r) && !ex.load) return 2'b01;
    else if (slot_match(mem, r))            return 2'b10;
    else if (slot_match(wb, r))             return 2'b11;
    else                                    return 2'b00;
  endfunction

  // A single hazard flag regardless of how many ports hit the load, so both
  // ports depending on the same load still yield one stall sequence.
  assign hazard = ex_q.load &&
                  ((hz.id_uses_rs && slot_match(ex_q, hz.id_rs)) ||
                   (hz.id_uses_rt && slot_match(ex_q, hz.id_rt)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard) begin
          stall = 1'b1;
          // The first bubble is issued from RUN; STALL covers the remainder.
          if (LOAD_USE_STALLS > 1) begin
            state_d = STALL;
            cnt_d   = 2'(LOAD_USE_STALLS - 1);
          end
        end
      end
      STALL: begin
        // Hazards seen here are ignored: EX only ever holds bubbles now.
        stall = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign ex_d = stall ? '0 : '{dest: hz.id_dest, rf_en: hz.id_rf_enable, load: hz.id_load_instr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset clears the slots and state asynchronously, so these settle to the
  // idle values (no stall, RF selects) for as long as reset is held.
  assign hz.control_mux      = stall;
  assign hz.pc_load_enable   = !stall;
  assign hz.ifid_load_enable = !stall;
  assign hz.hazard_state     = (state_q == STALL);
  assign hz.fwd_sel_a        = fwd_sel(hz.id_rs, hz.id_uses_rs, ex_q, mem_q, wb_q);
  assign hz.fwd_sel_b        = fwd_sel(hz.id_rt, hz.id_uses_rt, ex_q, mem_q, wb_q);

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  assign stall_count_d = (stall && (stall_count_q != 32'hFFFF_FFFF)) ? stall_count_q + 32'd1
                                                                      : stall_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign hz.stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed bench for hazard_forwarding_unit: one instance with 1 load-use bubble, one with 3.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
// Outputs compared as {control_mux, pc_load_enable, ifid_load_enable, fwd_sel_a, fwd_sel_b, hazard_state}.
module tb_hazard_forwarding_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_forwarding_unit_if #(.REG_ADDR_W(5)) if1 ();
  hazard_forwarding_unit_if #(.REG_ADDR_W(5)) if3 ();

  hazard_forwarding_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1)) dut1 (
    .clk(clk), .reset(reset), .hz(if1.slave));
  hazard_forwarding_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3)) dut3 (
    .clk(clk), .reset(reset), .hz(if3.slave));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0] rs, rt, dest;
    logic       urs, urt, rf, ld;
    logic [7:0] exp;      // {cm, pc, ifid, fa[1:0], fb[1:0], hs}
    logic       chk_fwd;  // selects are don't-care while stalling
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                              input logic urt, input logic [4:0] dest, input logic rf,
                              input logic ld, input logic [7:0] exp, input logic chk_fwd);
    vec_t v;
    v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    v.dest = dest; v.rf = rf; v.ld = ld; v.exp = exp; v.chk_fwd = chk_fwd;
    return v;
  endfunction

  function automatic logic [7:0] obs1();
    return {if1.control_mux, if1.pc_load_enable, if1.ifid_load_enable,
            if1.fwd_sel_a, if1.fwd_sel_b, if1.hazard_state};
  endfunction

  function automatic logic [7:0] obs3();
    return {if3.control_mux, if3.pc_load_enable, if3.ifid_load_enable,
            if3.fwd_sel_a, if3.fwd_sel_b, if3.hazard_state};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive1(input vec_t v);
    if1.id_rs = v.rs; if1.id_uses_rs = v.urs; if1.id_rt = v.rt; if1.id_uses_rt = v.urt;
    if1.id_dest = v.dest; if1.id_rf_enable = v.rf; if1.id_load_instr = v.ld;
  endtask

  task automatic drive3(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                        input logic [4:0] dest, input logic rf, input logic ld);
    if3.id_rs = rs; if3.id_uses_rs = urs; if3.id_rt = rt; if3.id_uses_rt = urt;
    if3.id_dest = dest; if3.id_rf_enable = rf; if3.id_load_instr = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] IDLE = 8'b0_1_1_00_00_0;
  localparam logic [7:0] STL  = 8'b1_0_0_00_00_0;

  initial begin
    vec_t idle_v;
    logic [7:0] m;
    logic [3:0] stall_exp[4];

    //            rs urs rt urt dest rf ld  expected               chk_fwd
    tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0, IDLE,                  1);  // idle
    tbl[1]  = mk(1, 1, 2, 1, 5,  1, 0, IDLE,                  1);  // ADD $5
    tbl[2]  = mk(5, 1, 6, 1, 7,  1, 0, 8'b0_1_1_01_00_0,      1);  // SUB rs=$5 -> EX
    tbl[3]  = mk(5, 1, 7, 1, 9,  1, 0, 8'b0_1_1_10_01_0,      1);  // $5 in MEM, $7 in EX
    tbl[4]  = mk(5, 1, 9, 1, 0,  0, 0, 8'b0_1_1_11_01_0,      1);  // $5 in WB, $9 in EX
    tbl[5]  = mk(0, 1, 0, 1, 0,  1, 0, IDLE,                  1);  // producer of $0
    tbl[6]  = mk(0, 1, 0, 1, 0,  0, 0, IDLE,                  1);  // reader of $0
    tbl[7]  = mk(0, 1, 0, 1, 0,  1, 1, IDLE,                  1);  // load into $0
    tbl[8]  = mk(0, 1, 0, 1, 0,  0, 0, IDLE,                  1);  // $0 load-use: no stall
    tbl[9]  = mk(0, 0, 0, 0, 3,  1, 0, IDLE,                  1);  // producer A $3
    tbl[10] = mk(0, 0, 0, 0, 3,  1, 0, IDLE,                  1);  // producer B $3
    tbl[11] = mk(3, 1, 3, 1, 0,  0, 0, 8'b0_1_1_01_01_0,      1);  // EX and MEM $3: EX wins
    tbl[12] = mk(3, 0, 3, 1, 0,  0, 0, 8'b0_1_1_00_10_0,      1);  // unused A; MEM beats WB
    tbl[13] = mk(1, 1, 8, 0, 8,  1, 1, IDLE,                  1);  // LW $8
    tbl[14] = mk(2, 1, 8, 1, 10, 1, 0, STL,                   0);  // load-use on rt
    tbl[15] = mk(2, 1, 8, 1, 10, 1, 0, 8'b0_1_1_00_10_0,      1);  // held; resolved via MEM
    tbl[16] = mk(10,1, 8, 1, 0,  0, 0, 8'b0_1_1_01_11_0,      1);  // $10 EX, $8 WB
    tbl[17] = mk(0, 0, 0, 0, 4,  1, 1, IDLE,                  1);  // LW $4
    tbl[18] = mk(4, 1, 4, 1, 0,  0, 0, STL,                   0);  // both ports on same load
    tbl[19] = mk(4, 1, 4, 1, 0,  0, 0, 8'b0_1_1_10_10_0,      1);  // one bubble only

    idle_v = mk(0, 0, 0, 0, 0, 0, 0, IDLE, 1);
    drive1(idle_v);
    drive3(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    step();
    check("reset_dut1", {24'd0, obs1()}, {24'd0, IDLE});
    check("reset_dut3", {24'd0, obs3()}, {24'd0, IDLE});
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive1(tbl[i]);
      #4;
      m = tbl[i].chk_fwd ? 8'hFF : 8'b1110_0001;
      check($sformatf("vec%0d", i), {24'd0, obs1() & m}, {24'd0, tbl[i].exp & m});
      step();
    end

    // Reset asserted with producers resident in the slots.
    drive1(mk(0, 0, 0, 0, 5, 1, 0, IDLE, 1));
    step();
    drive1(mk(5, 1, 5, 1, 0, 0, 0, IDLE, 1));
    #4;
    check("pre_reset_fwd", {24'd0, obs1()}, {24'd0, 8'b0_1_1_01_01_0});
    step();
    reset = 1'b1;
    #4;
    check("reset_midstream", {24'd0, obs1()}, {24'd0, IDLE});
    step();
    reset = 1'b0;
    #4;
    check("after_reset_slots_clear", {24'd0, obs1()}, {24'd0, IDLE});
    step();

    // Three-bubble load-use: control bits {cm, pc, ifid, hs} per cycle.
    stall_exp[0] = 4'b1_0_0_0;
    stall_exp[1] = 4'b1_0_0_1;
    stall_exp[2] = 4'b1_0_0_1;
    stall_exp[3] = 4'b0_1_1_0;
    drive3(0, 0, 0, 0, 8, 1, 1);
    #4;
    check("lus3_lw_issue", {24'd0, obs3()}, {24'd0, IDLE});
    step();
    drive3(0, 0, 8, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #4;
      check($sformatf("lus3_cycle%0d", k),
            {28'd0, if3.control_mux, if3.pc_load_enable, if3.ifid_load_enable, if3.hazard_state},
            {28'd0, stall_exp[k]});
      step();
    end
    #4;
    check("lus3_resumed_no_fwd", {24'd0, obs3()}, {24'd0, IDLE});
`ifdef HAZARD_STALL_COUNT_EN
    check("lus3_stall_count", if3.stall_count, 32'd3);
`endif
    step();

    // Reset in the middle of a stall sequence abandons it.
    drive3(0, 0, 0, 0, 9, 1, 1);
    step();
    drive3(9, 1, 0, 0, 0, 0, 0);
    #4;
    check("midstall_first", {24'd0, obs3()}, {24'd0, STL});
    step();
    #4;
    check("midstall_in_stall", {24'd0, obs3() & 8'b1110_0001}, {24'd0, 8'b1_0_0_00_00_1});
    reset = 1'b1;
    #1;
    check("midstall_reset", {24'd0, obs3()}, {24'd0, IDLE});
    step();
    reset = 1'b0;
    #4;
    check("midstall_after_reset", {24'd0, obs3()}, {24'd0, IDLE});
    step();
    #4;
    check("midstall_stays_run", {24'd0, obs3()}, {24'd0, IDLE});
`ifdef HAZARD_STALL_COUNT_EN
    check("midstall_count_cleared", if3.stall_count, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
